seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 16-bit combinational ALU.
- Uses the same 4-bit opcode map and N/Z flags.
- Adds a C flag, an error flag, iterative shift-add multiply, restoring divide and valid/ready handshakes on both sides.
- Sits between register-file read and write-back; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  4  0001 ADD, 0010 SUB, 0100 MUL, 0101 DIV, 0110 CMP; others illegal.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result (registered).
- n  out  1  result[WIDTH-1].
- z  out  1  result == 0.
- c  out  1  ADD carry-out; SUB/CMP borrow (a<b unsigned); 0 for MUL/DIV.
- err  out  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; result, n, z, c, err, out_valid = 0; counter and internal accumulators cleared. In-flight operation is discarded, not resumed.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). Accept = in_valid & in_ready; a, b, opcode are latched at accept.
- IDLE, accept of ADD/SUB/CMP/illegal: compute in the same cycle, register, go to DONE. out_valid rises on the cycle after the accept edge (latency 1).
- IDLE, accept of MUL/DIV: go to BUSY, counter = WIDTH. One iteration per cycle; on counter reaching 0 go to DONE. out_valid rises WIDTH+1 cycles after the accept edge (17 at default).
- MUL: unsigned shift-add. result = low WIDTH bits of a*b; upper bits dropped, no overflow flag.
- DIV: unsigned restoring divide. result = quotient; remainder kept internally (see Optional Feature).
- Divide-by-zero (b==0): no BUSY phase; straight to DONE with latency 1, result = all ones, err=1.
- CMP: result = a-b, written as a normal result; the write-back stage decides whether to commit it.
- ADD/SUB wrap modulo 2^WIDTH.
- Illegal opcode: result=0, z=1, n=0, c=0, err=1, latency 1.
- n and z are computed from the final registered result for every op.
- DONE: outputs held stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE and clear out_valid next cycle; result and flags keep their values. in_ready returns the cycle after the DONE handshake (no same-cycle turnaround).
- in_valid is ignored in BUSY/DONE; operands may change freely there.

Optional Feature:
- Macro SEQ_ALU_REM_EN.
- Defined: extra output port rem (WIDTH bits, out), valid with out_valid. Gives the DIV remainder; rem=a on divide-by-zero; 0 for all other ops; reset 0.
- Undefined: no rem port; remainder register may be optimised away. All other behaviour identical.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD=4'b0001, OP_SUB, OP_MUL, OP_DIV, OP_CMP) and state encoding (IDLE, BUSY, DONE). Decoder, control unit and bench import the same package.
- One natural sub-module: seq_alu_muldiv, holding the iterative multiply/divide datapath (accumulator, shift registers, counter). Interface: start, is_div, a, b, done, prod_quot, rem. The top keeps the FSM, the combinational ops and the flags.

Test Plan:
- ADD a=0xFFFF b=0x0001 -> out_valid 1 cycle after accept, result=0x0000, z=1, c=1, n=0, err=0.
- CMP a=3 b=5 -> result=0xFFFE, n=1, z=0, c=1; CMP a=7 b=7 -> z=1, c=0.
- MUL a=300 b=300 -> result=0x5F90 exactly 17 cycles after accept; in_ready=0 throughout.
- DIV a=100 b=7 -> result=14 (rem=2 with SEQ_ALU_REM_EN), latency 17; DIV a=5 b=0 -> result=0xFFFF, err=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL -> result/flags stable, in_ready=0; after out_ready pulse, in_ready=1 next cycle. Opcode 4'b1111 -> result=0, err=1.
- Assert reset 5 cycles into a DIV -> all outputs 0 immediately; next ADD 2+2 returns 4 with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM state encoding
// and a small opcode classification helper. Imported by the control unit,
// the datapath and the testbench.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_CMP = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the opcodes that run on the iterative multiply/divide datapath.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bus of the sequential ALU. The master side (control unit or
// testbench) presents operands and consumes results; the slave side is the ALU.
// The rem signal only exists when SEQ_ALU_REM_EN is defined. state is a debug
// view of the ALU control FSM.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             n;
    logic             z;
    logic             c;
    logic             err;
`ifdef SEQ_ALU_REM_EN
    logic [WIDTH-1:0] rem;
`endif
    state_t           state;

`ifdef SEQ_ALU_REM_EN
    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, n, z, c, err, rem, state
    );
    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, n, z, c, err, rem, state
    );
`else
    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, n, z, c, err, state
    );
    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, n, z, c, err, state
    );
`endif

endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide datapath: one shift-add (MUL) or one restoring
// subtract step (DIV) per clock, WIDTH steps per operation. done is high
// during the final step; prod_quot/rem then carry the value that step
// produces so the caller can register it on the same edge.
module seq_alu_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_quot,
    output logic [WIDTH-1:0] rem
);

    // MUL: acc = partial product, sh = multiplier (shifts right), op = multiplicand (shifts left)
    // DIV: acc = partial remainder, sh = dividend/quotient (shifts left), op = divisor
    logic [WIDTH-1:0] acc_q, sh_q, op_q;
    logic [WIDTH-1:0] acc_n, sh_n, op_n;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Next value of the datapath registers for one iteration.
    always_comb begin
        acc_n = acc_q;
        sh_n  = sh_q;
        op_n  = op_q;
        trial = {acc_q, sh_q[WIDTH-1]};
        diff  = trial - {1'b0, op_q};
        if (div_q) begin
            // diff[WIDTH] set means the trial subtraction borrowed: restore.
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                sh_n  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = trial[WIDTH-1:0];
                sh_n  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = acc_q + (sh_q[0] ? op_q : '0);
            op_n  = op_q << 1;
            sh_n  = sh_q >> 1;
        end
    end

    // Load operands on start, then iterate until the counter runs out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            sh_q  <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            acc_q <= '0;
            div_q <= is_div;
            cnt_q <= CNT_W'(WIDTH);
            sh_q  <= is_div ? a : b;
            op_q  <= is_div ? b : a;
        end else if (cnt_q != '0) begin
            acc_q <= acc_n;
            sh_q  <= sh_n;
            op_q  <= op_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done      = (cnt_q == CNT_W'(1));
    assign prod_quot = div_q ? sh_n : acc_n;
    assign rem       = div_q ? acc_n : '0;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: ADD/SUB/CMP and illegal opcodes finish in one cycle, MUL and
// DIV run WIDTH iterations on seq_alu_muldiv. Holds the control FSM, the
// single-cycle operations and the registered flags.
// Optional macro SEQ_ALU_REM_EN adds the DIV remainder output (bus.rem).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; in_valid is ignored otherwise.
// Once out_valid is high, result and flags stay stable until out_ready is
// seen, after which the FSM returns to IDLE (in_ready rises the next cycle).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);

    state_t           state_q, state_d;
    logic             start;
    logic             load_fast;
    logic             div_zero;
    logic             md_op;
    logic             md_done;
    logic [WIDTH-1:0] md_pq;
    logic [WIDTH-1:0] md_rem;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] fast_rem;
    logic             fast_c;
    logic             fast_err;

    logic [WIDTH-1:0] result_q;
    logic             n_q, z_q, c_q, err_q;

    assign div_zero = (bus.opcode == OP_DIV) && (bus.b == '0);
    assign md_op    = is_muldiv(bus.opcode) && !div_zero;

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_div    (bus.opcode == OP_DIV),
        .a         (bus.a),
        .b         (bus.b),
        .done      (md_done),
        .prod_quot (md_pq),
        .rem       (md_rem)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        load_fast = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (md_op) begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end else begin
                        load_fast = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            BUSY: if (md_done) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle operations, divide-by-zero and illegal opcodes.
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        dif      = {1'b0, bus.a} - {1'b0, bus.b};
        fast_res = '0;
        fast_rem = '0;
        fast_c   = 1'b0;
        fast_err = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                fast_res = sum[WIDTH-1:0];
                fast_c   = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                fast_res = dif[WIDTH-1:0];
                fast_c   = dif[WIDTH];
            end
            OP_DIV: begin
                // Only reached here with b == 0.
                fast_res = '1;
                fast_rem = bus.a;
                fast_err = 1'b1;
            end
            OP_MUL: ;
            default: fast_err = 1'b1;
        endcase
    end

    // Result and flag registers; n/z derive from the value being registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            err_q    <= 1'b0;
        end else if (load_fast) begin
            result_q <= fast_res;
            n_q      <= fast_res[WIDTH-1];
            z_q      <= (fast_res == '0);
            c_q      <= fast_c;
            err_q    <= fast_err;
        end else if (md_done) begin
            result_q <= md_pq;
            n_q      <= md_pq[WIDTH-1];
            z_q      <= (md_pq == '0);
            c_q      <= 1'b0;
            err_q    <= 1'b0;
        end
    end

`ifdef SEQ_ALU_REM_EN
    logic [WIDTH-1:0] rem_q;

    // Remainder register, updated alongside the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          rem_q <= '0;
        else if (load_fast) rem_q <= fast_rem;
        else if (md_done)   rem_q <= md_rem;
    end

    assign bus.rem = rem_q;
`else
    logic unused_rem;
    assign unused_rem = ^{md_rem, fast_rem};
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.n         = n_q;
    assign bus.z         = z_q;
    assign bus.c         = c_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vector table, backpressure and mid-operation
// reset sequences, then randomized operations against a behavioural model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 16;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] res;
        logic         n, z, c, err;
        logic [W-1:0] rem;
        int           lat;
        logic         ready_hi;
    } outcome_t;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        outcome_t     exp;
    } vec_t;

    seq_alu_if #(.WIDTH(W)) bus();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic outcome_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        outcome_t o;
        longint ai = longint'(a);
        longint bi = longint'(b);
        longint m  = longint'(1) << W;
        longint r  = 0;
        o.c = 1'b0; o.err = 1'b0; o.rem = '0; o.lat = 1; o.ready_hi = 1'b0;
        case (op)
            OP_ADD: begin r = ai + bi; o.c = (r >= m); r = r % m; end
            OP_SUB, OP_CMP: begin o.c = (ai < bi); r = (ai - bi + m) % m; end
            OP_MUL: begin r = (ai * bi) % m; o.lat = W + 1; end
            OP_DIV: begin
                if (bi == 0) begin r = m - 1; o.err = 1'b1; o.rem = a; end
                else begin r = ai / bi; o.rem = W'(ai % bi); o.lat = W + 1; end
            end
            default: begin r = 0; o.err = 1'b1; end
        endcase
        o.res = W'(r);
        o.n   = (r >= m / 2);
        o.z   = (r == 0);
        return o;
    endfunction

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res, input logic n,
                                input logic z, input logic c, input logic err,
                                input logic [W-1:0] rem, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.exp.res = res; v.exp.n = n; v.exp.z = z; v.exp.c = c; v.exp.err = err;
        v.exp.rem = rem; v.exp.lat = lat; v.exp.ready_hi = 1'b0;
        return v;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outcome(input string tag, input outcome_t act, input outcome_t exp);
        check({tag, ".result"}, 32'(act.res), 32'(exp.res));
        check({tag, ".n"}, 32'(act.n), 32'(exp.n));
        check({tag, ".z"}, 32'(act.z), 32'(exp.z));
        check({tag, ".c"}, 32'(act.c), 32'(exp.c));
        check({tag, ".err"}, 32'(act.err), 32'(exp.err));
        check({tag, ".latency"}, 32'(act.lat), 32'(exp.lat));
        check({tag, ".in_ready_while_busy"}, 32'(act.ready_hi), 32'(exp.ready_hi));
`ifdef SEQ_ALU_REM_EN
        check({tag, ".rem"}, 32'(act.rem), 32'(exp.rem));
`endif
    endtask

    // ---------------- drivers ----------------
    // Issue one operation and wait for out_valid; does not acknowledge it.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output outcome_t o);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.opcode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Operands and in_valid are junk from here on; the ALU must ignore them.
        bus.opcode = 4'($urandom_range(0, 15));
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
        o.lat      = 1;
        o.ready_hi = 1'b0;
        while (!bus.out_valid && o.lat < 100) begin
            o.ready_hi |= bus.in_ready;
            @(posedge clk); #1;
            o.lat++;
        end
        o.ready_hi |= bus.in_ready;
        bus.in_valid = 1'b0;
        if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        o.res = bus.result;
        o.n   = bus.n;
        o.z   = bus.z;
        o.c   = bus.c;
        o.err = bus.err;
`ifdef SEQ_ALU_REM_EN
        o.rem = bus.rem;
`else
        o.rem = '0;
`endif
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t     vecs[14];
    outcome_t o;
    outcome_t e;

    initial begin
        vecs[0]  = mk("add_wrap",   OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1, 0, 16'h0000, 1);
        vecs[1]  = mk("add_sign",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 0, 16'h0000, 1);
        vecs[2]  = mk("sub_plain",  OP_SUB, 16'h1000, 16'h0001, 16'h0FFF, 0, 0, 0, 0, 16'h0000, 1);
        vecs[3]  = mk("sub_borrow", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1, 0, 16'h0000, 1);
        vecs[4]  = mk("cmp_lt",     OP_CMP, 16'h0003, 16'h0005, 16'hFFFE, 1, 0, 1, 0, 16'h0000, 1);
        vecs[5]  = mk("cmp_eq",     OP_CMP, 16'h0007, 16'h0007, 16'h0000, 0, 1, 0, 0, 16'h0000, 1);
        vecs[6]  = mk("mul_300",    OP_MUL, 16'd300,  16'd300,  16'h5F90, 0, 0, 0, 0, 16'h0000, 17);
        vecs[7]  = mk("mul_max",    OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 17);
        vecs[8]  = mk("div_100_7",  OP_DIV, 16'd100,  16'd7,    16'd14,   0, 0, 0, 0, 16'd2,    17);
        vecs[9]  = mk("div_zero",   OP_DIV, 16'd5,    16'd0,    16'hFFFF, 1, 0, 0, 1, 16'd5,    1);
        vecs[10] = mk("illegal",    4'hF,   16'h1234, 16'h5678, 16'h0000, 0, 1, 0, 1, 16'h0000, 1);
        vecs[11] = mk("div_small",  OP_DIV, 16'd3,    16'h8000, 16'h0000, 0, 1, 0, 0, 16'd3,    17);
        vecs[12] = mk("div_by_one", OP_DIV, 16'hFFFF, 16'd1,    16'hFFFF, 1, 0, 0, 0, 16'd0,    17);
        vecs[13] = mk("mul_zero",   OP_MUL, 16'h0000, 16'hABCD, 16'h0000, 0, 1, 0, 0, 16'h0000, 17);

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.flags", 32'({bus.n, bus.z, bus.c, bus.err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, o);
            check_outcome(vecs[i].name, o, vecs[i].exp);
            release_out();
            check({vecs[i].name, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
            check({vecs[i].name, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: hold the MUL result for 5 cycles while junk is offered.
        run_op(OP_MUL, 16'd300, 16'd300, o);
        check("bp.result", 32'(o.res), 32'h5F90);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_ADD;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            check("bp.hold_result", 32'(bus.result), 32'h5F90);
            check("bp.hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp.hold_flags", 32'({bus.n, bus.z, bus.c, bus.err}), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        check("bp.in_ready_after", 32'(bus.in_ready), 32'd1);
        check("bp.out_valid_after", 32'(bus.out_valid), 32'd0);
        check("bp.result_kept", 32'(bus.result), 32'h5F90);

        // Reset five cycles into a DIV: everything clears, nothing resumes.
        @(negedge clk);
        bus.opcode   = OP_DIV;
        bus.a        = 16'd100;
        bus.b        = 16'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.result", 32'(bus.result), 32'd0);
        check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid.flags", 32'({bus.n, bus.z, bus.c, bus.err}), 32'd0);
`ifdef SEQ_ALU_REM_EN
        check("rst_mid.rem", 32'(bus.rem), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid.no_resume", 32'(bus.out_valid), 32'd0);
        check("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
        run_op(OP_ADD, 16'd2, 16'd2, o);
        check_outcome("rst_mid.add", o, model(OP_ADD, 16'd2, 16'd2));
        check("rst_mid.add_value", 32'(o.res), 32'd4);
        release_out();

        // Randomized operations against the behavioural model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op;
            logic [W-1:0] ra, rb;
            case ($urandom_range(0, 5))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_MUL;
                3: op = OP_DIV;
                4: op = OP_CMP;
                default: begin
                    op = 4'($urandom_range(0, 15));
                    while (op == OP_ADD || op == OP_SUB || op == OP_MUL ||
                           op == OP_DIV || op == OP_CMP)
                        op = 4'($urandom_range(0, 15));
                end
            endcase
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 15));
            e  = model(op, ra, rb);
            exp_q.push_back(e.res);
            run_op(op, ra, rb, o);
            e.res = exp_q.pop_front();
            check_outcome("rand", o, e);
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
